// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch (if_*) and data-memory (dm_*) requesters. Data accesses
// win contested cycles; read data is routed back to its owner one cycle later.
// Optional macro ARB_STARVE_GUARD_EN bounds how long fetch can be locked out:
// after STARVE_MAX consecutive contested losses, fetch wins the next contest.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e            owner_q;
  logic              dm_rd_q;
  logic [DATA_W-1:0] if_hold_q;
  logic [DATA_W-1:0] dm_hold_q;
  logic              if_grant;
  logic              dm_grant;
  logic              if_priority;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  assign if_priority = (starve_cnt == CNT_W'(STARVE_MAX));

  // Count consecutive contested cycles that fetch lost; saturates at the limit
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_grant) begin
      starve_cnt <= '0;
    end else if (dm_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  // Guard absent: strict data priority, counter tied off
  logic [CNT_W-1:0] unused_starve_cnt;
  assign unused_starve_cnt = '0;
  assign if_priority       = 1'b0;
`endif

  // Grant selection: data wins unless fetch has been starved; none in reset
  always_comb begin
    if_grant = 1'b0;
    dm_grant = 1'b0;
    if (Reset) begin
      if (dm_req && !(if_req && if_priority)) begin
        dm_grant = 1'b1;
      end else if (if_req) begin
        if_grant = 1'b1;
      end
    end
  end

  assign if_stall = if_req & ~if_grant;
  assign dm_stall = dm_req & ~dm_grant;

  // Memory port mux driven by the granted requester
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_grant) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_we ? dm_be : 4'hF;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_grant) begin
      mem_en    = 1'b1;
      mem_be    = 4'hF;
      mem_addr  = if_addr;
    end
  end

  // Owner tracking, response valids and per-requester read-data hold registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      owner_q   <= OWN_NONE;
      dm_rd_q   <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      if (owner_q == OWN_IF) begin
        if_hold_q <= mem_rdata;
      end
      if ((owner_q == OWN_DM) && dm_rd_q) begin
        dm_hold_q <= mem_rdata;
      end
      if (if_grant) begin
        owner_q <= OWN_IF;
      end else if (dm_grant) begin
        owner_q <= OWN_DM;
      end else begin
        owner_q <= OWN_NONE;
      end
      dm_rd_q  <= dm_grant & ~dm_we;
      if_valid <= if_grant;
      dm_valid <= dm_grant;
    end
  end

  // Live memory data in the response cycle, otherwise the last delivered value
  assign if_rdata = (owner_q == OWN_IF) ? mem_rdata : if_hold_q;
  assign dm_rdata = ((owner_q == OWN_DM) && dm_rd_q) ? mem_rdata : dm_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              Clk;
  logic              Reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_stall;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_stall(dm_stall), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; inputs are then changed 1 time unit after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    if_req   = 1'b0; if_addr  = '0;
    dm_req   = 1'b0; dm_we    = 1'b0; dm_be = 4'h0;
    dm_addr  = '0;   dm_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b0; if_req = 1'b1; dm_req = 1'b1; mem_rdata = 32'h5555AAAA;
    tick(); tick();
    #1;
    n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL reset_if_stall got %b want 1", if_stall); end
    n_checks++; if (dm_stall !== 1'b1) begin n_fail++; $display("FAIL reset_dm_stall got %b want 1", dm_stall); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    n_checks++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dm_valid got %b want 0", dm_valid); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata got %h want 0", if_rdata); end
    n_checks++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_rdata got %h want 0", dm_rdata); end
    idle();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_en got %b want 1", mem_en); end
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_mem_addr got %h want 10", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_be !== 4'hF) begin n_fail++; $display("FAIL fetch_mem_be got %h want f", mem_be); end
    n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_if_stall got %b want 0", if_stall); end
    tick();
    if_req = 1'b0; mem_rdata = 32'h8C080004;
    #1;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_if_valid got %b want 1", if_valid); end
    n_checks++; if (if_rdata !== 32'h8C080004) begin n_fail++; $display("FAIL fetch_if_rdata got %h want 8c080004", if_rdata); end
    tick();
    mem_rdata = 32'h12345678;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_drop got %b want 0", if_valid); end
    n_checks++; if (if_rdata !== 32'h8C080004) begin n_fail++; $display("FAIL fetch_rdata_hold got %h want 8c080004", if_rdata); end
    tick();
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
    #1;
    n_checks++; if (dm_stall !== 1'b0) begin n_fail++; $display("FAIL cont_dm_stall got %b want 0", dm_stall); end
    n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL cont_if_stall got %b want 1", if_stall); end
    n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL cont_mem_addr got %h want 40", mem_addr); end
    tick();
    dm_req = 1'b0; mem_rdata = 32'hA5A50001;
    #1;
    n_checks++; if (dm_valid !== 1'b1) begin n_fail++; $display("FAIL cont_dm_valid got %b want 1", dm_valid); end
    n_checks++; if (dm_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL cont_dm_rdata got %h want a5a50001", dm_rdata); end
    n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL cont_if_retry got %b want 0", if_stall); end
    n_checks++; if (mem_addr !== 32'h20) begin n_fail++; $display("FAIL cont_retry_addr got %h want 20", mem_addr); end
    tick();
    if_req = 1'b0; mem_rdata = 32'h0BADF00D;
    #1;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL cont_if_valid got %b want 1", if_valid); end
    n_checks++; if (if_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL cont_if_rdata got %h want 0badf00d", if_rdata); end
    n_checks++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL cont_dm_valid_drop got %b want 0", dm_valid); end
    n_checks++; if (dm_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL cont_dm_hold got %h want a5a50001", dm_rdata); end
    tick();
  endtask

  task automatic test_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    #1;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
    n_checks++; if (mem_be !== 4'b0011) begin n_fail++; $display("FAIL wr_mem_be got %b want 0011", mem_be); end
    n_checks++; if (mem_addr !== 32'h44) begin n_fail++; $display("FAIL wr_mem_addr got %h want 44", mem_addr); end
    n_checks++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_wdata got %h want deadbeef", mem_wdata); end
    tick();
    idle(); mem_rdata = 32'hFFFFFFFF;
    #1;
    n_checks++; if (dm_valid !== 1'b1) begin n_fail++; $display("FAIL wr_ack got %b want 1", dm_valid); end
    n_checks++; if (dm_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL wr_rdata_kept got %h want a5a50001", dm_rdata); end
    tick();
    #1;
    n_checks++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL wr_ack_drop got %b want 0", dm_valid); end
    tick();
  endtask

  task automatic test_starve();
    bit exp_if;
    for (int i = 0; i < 3 * (STARVE_MAX + 1); i++) begin
      if_req = 1'b1; if_addr = 32'h100 + 32'(i);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200 + 32'(i);
      #1;
      exp_if = GUARD && ((i % (STARVE_MAX + 1)) == STARVE_MAX);
      n_checks++; if (if_stall !== !exp_if) begin n_fail++; $display("FAIL starve_if_stall[%0d] got %b want %b", i, if_stall, !exp_if); end
      n_checks++; if (dm_stall !== exp_if) begin n_fail++; $display("FAIL starve_dm_stall[%0d] got %b want %b", i, dm_stall, exp_if); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midflight();
    if_req = 1'b1; if_addr = 32'h30; mem_rdata = 32'h0;
    tick();
    Reset = 1'b0; mem_rdata = 32'hCAFE0001;
    tick();
    mem_rdata = 32'hCAFE0002;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_if_valid got %b want 0", if_valid); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_if_rdata got %h want 0", if_rdata); end
    n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_if_stall got %b want 1", if_stall); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_en got %b want 0", mem_en); end
    idle();
    Reset = 1'b1;
    tick();
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_late_valid got %b want 0", if_valid); end
    n_checks++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_dm_rdata got %h want 0", dm_rdata); end
    tick();
  endtask

  // Random traffic against a model built from the arbitration rules
  task automatic test_random();
    bit m_if_pend, m_dm_rd_pend, m_dm_wr_pend;
    logic [DATA_W-1:0] m_if_last, m_dm_last;
    int m_starve;
    bit e_if_g, e_dm_g;
    logic [DATA_W-1:0] e_if_rd, e_dm_rd;
    m_if_pend = 0; m_dm_rd_pend = 0; m_dm_wr_pend = 0;
    m_if_last = '0; m_dm_last = '0; m_starve = 0;
    for (int i = 0; i < 400; i++) begin
      Reset     = (i == 0) ? 1'b0 : ($urandom_range(15) != 0);
      if_req    = ($urandom_range(3) != 0);
      if_addr   = $urandom;
      dm_req    = ($urandom_range(3) != 0);
      dm_we     = $urandom_range(1);
      dm_be     = 4'($urandom);
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      mem_rdata = $urandom;
      #1;
      e_dm_g  = Reset && dm_req && !(if_req && GUARD && (m_starve >= STARVE_MAX));
      e_if_g  = Reset && if_req && !e_dm_g;
      e_if_rd = m_if_pend ? mem_rdata : m_if_last;
      e_dm_rd = m_dm_rd_pend ? mem_rdata : m_dm_last;
      n_checks++; if (if_stall !== (if_req && !e_if_g)) begin n_fail++; $display("FAIL rnd_if_stall[%0d] got %b want %b", i, if_stall, if_req && !e_if_g); end
      n_checks++; if (dm_stall !== (dm_req && !e_dm_g)) begin n_fail++; $display("FAIL rnd_dm_stall[%0d] got %b want %b", i, dm_stall, dm_req && !e_dm_g); end
      n_checks++; if (mem_en !== (e_if_g || e_dm_g)) begin n_fail++; $display("FAIL rnd_mem_en[%0d] got %b want %b", i, mem_en, e_if_g || e_dm_g); end
      n_checks++; if (mem_we !== (e_dm_g && dm_we)) begin n_fail++; $display("FAIL rnd_mem_we[%0d] got %b want %b", i, mem_we, e_dm_g && dm_we); end
      if (e_dm_g) begin
        n_checks++; if (mem_addr !== dm_addr) begin n_fail++; $display("FAIL rnd_dm_addr[%0d] got %h want %h", i, mem_addr, dm_addr); end
        n_checks++; if (mem_be !== (dm_we ? dm_be : 4'hF)) begin n_fail++; $display("FAIL rnd_dm_be[%0d] got %h want %h", i, mem_be, dm_we ? dm_be : 4'hF); end
        n_checks++; if (dm_we && (mem_wdata !== dm_wdata)) begin n_fail++; $display("FAIL rnd_dm_wdata[%0d] got %h want %h", i, mem_wdata, dm_wdata); end
      end else if (e_if_g) begin
        n_checks++; if (mem_addr !== if_addr) begin n_fail++; $display("FAIL rnd_if_addr[%0d] got %h want %h", i, mem_addr, if_addr); end
        n_checks++; if (mem_be !== 4'hF) begin n_fail++; $display("FAIL rnd_if_be[%0d] got %h want f", i, mem_be); end
      end else begin
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rnd_idle_addr[%0d] got %h want 0", i, mem_addr); end
      end
      n_checks++; if (if_valid !== m_if_pend) begin n_fail++; $display("FAIL rnd_if_valid[%0d] got %b want %b", i, if_valid, m_if_pend); end
      n_checks++; if (dm_valid !== (m_dm_rd_pend || m_dm_wr_pend)) begin n_fail++; $display("FAIL rnd_dm_valid[%0d] got %b want %b", i, dm_valid, m_dm_rd_pend || m_dm_wr_pend); end
      n_checks++; if (if_rdata !== e_if_rd) begin n_fail++; $display("FAIL rnd_if_rdata[%0d] got %h want %h", i, if_rdata, e_if_rd); end
      n_checks++; if (dm_rdata !== e_dm_rd) begin n_fail++; $display("FAIL rnd_dm_rdata[%0d] got %h want %h", i, dm_rdata, e_dm_rd); end
      // model state update at the coming edge
      if (!Reset) begin
        m_if_pend = 0; m_dm_rd_pend = 0; m_dm_wr_pend = 0;
        m_if_last = '0; m_dm_last = '0; m_starve = 0;
      end else begin
        m_if_last = e_if_rd;
        m_dm_last = e_dm_rd;
        m_if_pend = e_if_g;
        m_dm_rd_pend = e_dm_g && !dm_we;
        m_dm_wr_pend = e_dm_g && dm_we;
        if (!if_req || e_if_g) m_starve = 0;
        else if (dm_req && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end
      tick();
    end
    idle();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    Reset = 1'b0;
    mem_rdata = '0;
    #1;
    test_reset();
    test_fetch_read();
    test_contention();
    test_write();
    test_starve();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing one single-port synchronous memory between the instruction-fetch requester and the data-memory requester of the five-stage pipeline. Each cycle it grants the port to at most one requester, stalls the loser, and routes the read data back to its owner one cycle later. Data accesses win by default. An optional starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width
- STARVE_MAX, 4, number of consecutive denied fetch cycles before fetch wins a contested cycle (used only with the guard compiled in, ≥1)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_stall  out  1  fetch denied this cycle
- if_valid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_be  in  4  write byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_stall  out  1  data request denied this cycle
- dm_valid  out  1  data read data valid, or write acknowledge
- dm_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables, 4'hF on reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
Grant is combinational each cycle:
- Only one requester active: it is granted.
- Both requesters active: dm wins, unless the starvation guard is active (see Configuration).
- mem_* outputs mirror the granted requester's signals.
- No grant: mem_en=0, mem_we=0, mem_addr and mem_wdata = 0.

Stalls:
- if_stall = if_req & ~if_grant.
- dm_stall = dm_req & ~dm_grant.
- A stalled requester holds its request and payload stable until granted. The arbiter does not latch payloads.

Owner register:
- owner_q ∈ {NONE, IF, DM} records the grant.
- Next cycle, when owner_q = IF, if_valid = 1 and if_rdata = mem_rdata.
- Next cycle, when owner_q = DM, dm_valid = 1. dm_rdata = mem_rdata for reads. Writes give dm_valid = 1 with dm_rdata holding its previous value.
- When not valid, each rdata output holds the last value delivered to that requester, kept in hold registers.

Back-to-back grants to the same or alternating requesters are allowed every cycle. Throughput is one access per cycle.

Reset (Reset=0 at an edge):
- owner_q=NONE, if_valid=0, dm_valid=0, hold registers=0, starve_cnt=0.
- While Reset=0, all grants are forced to 0, so stall = req.
- Reset asserted mid-transaction drops the in-flight response: no valid is issued after reset.

## Timing
- Grant, stall and mem_* are same-cycle combinational from the requests.
- Read latency: grant in cycle N, valid and rdata in cycle N+1.
- Write acknowledge: dm_valid in cycle N+1.
- Outputs after reset: all valids 0, all rdata 0, mem_en 0.
- Simultaneous requests resolve in the same cycle; the loser retries in the next cycle.

## Configuration
Macro ARB_STARVE_GUARD_EN.

Defined:
- starve_cnt, width clog2(STARVE_MAX+1), increments each cycle with if_req & dm_req & ~if_grant. It saturates at STARVE_MAX.
- It clears when if is granted or if_req=0.
- When starve_cnt == STARVE_MAX and both request, if is granted and dm is stalled.

Undefined:
- Strict dm priority, no counter.
- Fetch can be stalled indefinitely under continuous dm_req.

## Test plan
- Reset with Reset=0 for 2 cycles, if_req=1 → if_stall=1, mem_en=0, if_valid=0, if_rdata=0.
- Fetch-only read at if_addr=0x10, memory returns 0x8C080004 → mem_addr=0x10 in cycle N, if_valid=1 with if_rdata=0x8C080004 in N+1. if_rdata holds that value afterward.
- Contention: both request, dm read at 0x40 → dm granted, if_stall=1. Next cycle dm_valid=1 and if granted. if_valid=1 one cycle later.
- dm write at 0x44 with dm_wdata=0xDEADBEEF, dm_be=4'b0011 → mem_we=1, mem_be=0011. dm_valid=1 in N+1 with dm_rdata unchanged.
- Guard defined, STARVE_MAX=4, both requesting continuously → dm granted 4 cycles, if granted on the 5th, pattern repeats. Guard undefined → if never granted.
- Reset asserted in the cycle after a read grant → no valid asserted, owner_q returns to NONE.
